mux_comportamental_4x1: RTL and testbench



---
 rtl/mux_pkg.sv | 14 +
 rtl/mux4_core.sv | 28 ++
 rtl/mux_comportamental_4x1.sv | 51 +++++
 tb/tb_mux_comportamental_4x1.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared select encoding for the 4:1 multiplexer.
// Select index is {S0, S1}; S0 is the MSB.
package mux_pkg;

    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_D0 = 2'b00;
    localparam sel_t SEL_D1 = 2'b01;
    localparam sel_t SEL_D2 = 2'b10;
    localparam sel_t SEL_D3 = 2'b11;

endpackage

// File: rtl/mux4_core.sv
// Combinational 4:1 selector.
// Any select value outside the four codes (X/Z) yields zero.
module mux4_core
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  sel_t             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    // Pick exactly one input; unselected inputs never reach y
    always_comb begin
        y = '0;
        case (sel)
            SEL_D0:  y = d0;
            SEL_D1:  y = d1;
            SEL_D2:  y = d2;
            SEL_D3:  y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux_comportamental_4x1.sv
// Behavioural 4:1 multiplexer with optional output register.
// REGISTERED=1 adds one cycle of latency and a synchronous reset.
module mux_comportamental_4x1
    import mux_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic             S0,
    input  logic             S1,
    output logic [WIDTH-1:0] Y
);

    sel_t             sel;
    logic [WIDTH-1:0] core_y;

    assign sel = {S0, S1};

    mux4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .sel (sel),
        .d0  (D0),
        .d1  (D1),
        .d2  (D2),
        .d3  (D3),
        .y   (core_y)
    );

    generate
        if (REGISTERED) begin : g_reg
            // Capture the selected word every edge; rst clears it
            always_ff @(posedge clk) begin
                if (rst) begin
                    Y <= '0;
                end else begin
                    Y <= core_y;
                end
            end
        end else begin : g_comb
            assign Y = core_y;
        end
    endgenerate

endmodule

// File: tb/tb_mux_comportamental_4x1.sv
// Directed bench for the 4:1 mux: registered WIDTH=1 and WIDTH=4,
// plus a combinational WIDTH=4 instance.
module tb_mux_comportamental_4x1;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // registered, WIDTH=1
    logic       rst1;
    logic       a0, a1, a2, a3;
    logic       as0, as1;
    logic       y1;

    // registered, WIDTH=4
    logic       rst4;
    logic [3:0] b0, b1, b2, b3;
    logic       bs0, bs1;
    logic [3:0] y4;

    // combinational, WIDTH=4
    logic       rstc;
    logic       cs0, cs1;
    logic [3:0] yc;

    mux_comportamental_4x1 #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
        .clk (clk), .rst (rst1),
        .D0 (a0), .D1 (a1), .D2 (a2), .D3 (a3),
        .S0 (as0), .S1 (as1), .Y (y1)
    );

    mux_comportamental_4x1 #(.WIDTH(4), .REGISTERED(1'b1)) u_r4 (
        .clk (clk), .rst (rst4),
        .D0 (b0), .D1 (b1), .D2 (b2), .D3 (b3),
        .S0 (bs0), .S1 (bs1), .Y (y4)
    );

    mux_comportamental_4x1 #(.WIDTH(4), .REGISTERED(1'b0)) u_c4 (
        .clk (clk), .rst (rstc),
        .D0 (b0), .D1 (b1), .D2 (b2), .D3 (b3),
        .S0 (cs0), .S1 (cs1), .Y (yc)
    );

    task automatic check(input logic [3:0] obs);
        item_t it;
        it = q.pop_front();
        total++;
        assert (obs === it.exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
        end
    endtask

    task automatic tick1(input string tag, input logic exp);
        q.push_back('{tag, {3'b000, exp}});
        @(posedge clk);
        #1;
        check({3'b000, y1});
    endtask

    task automatic tick4(input string tag, input logic [3:0] exp);
        q.push_back('{tag, exp});
        @(posedge clk);
        #1;
        check(y4);
    endtask

    task automatic comb(input string tag, input logic [3:0] exp);
        q.push_back('{tag, exp});
        #1;
        check(yc);
    endtask

    initial begin
        rst1 = 1'b0; rst4 = 1'b1; rstc = 1'b0;
        a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
        as0 = 1'b0; as1 = 1'b0;
        b0 = 4'h1; b1 = 4'h2; b2 = 4'h4; b3 = 4'h8;
        bs0 = 1'b0; bs1 = 1'b0;
        cs0 = 1'b0; cs1 = 1'b0;

        // reset with all data high and sel=11
        rst1 = 1'b1;
        a0 = 1'b1; a1 = 1'b1; a2 = 1'b1; a3 = 1'b1;
        as0 = 1'b1; as1 = 1'b1;
        tick1("rst_w1", 1'b0);
        rst1 = 1'b0;
        tick1("rel_w1", 1'b1);

        // sequential selection, unselected inputs unknown
        a0 = 1'b1; a1 = 1'bx; a2 = 1'bx; a3 = 1'bx;
        as0 = 1'b0; as1 = 1'b0;
        tick1("sel00_a", 1'b1);
        tick1("sel00_b", 1'b1);
        a0 = 1'bx; a1 = 1'b1;
        as0 = 1'b0; as1 = 1'b1;
        tick1("sel01_a", 1'b1);
        tick1("sel01_b", 1'b1);
        a1 = 1'bx; a2 = 1'b1;
        as0 = 1'b1; as1 = 1'b0;
        tick1("sel10_a", 1'b1);
        tick1("sel10_b", 1'b1);
        a2 = 1'bx; a3 = 1'b1;
        as0 = 1'b1; as1 = 1'b1;
        tick1("sel11_a", 1'b1);
        tick1("sel11_b", 1'b1);

        // S0 is the MSB
        a0 = 1'b0; a1 = 1'b1; a2 = 1'b0; a3 = 1'b0;
        as0 = 1'b0; as1 = 1'b1;
        tick1("order01", 1'b1);
        as0 = 1'b1; as1 = 1'b0;
        tick1("order10", 1'b0);

        // walking one, WIDTH=4
        rst4 = 1'b1;
        tick4("rst_w4", 4'h0);
        rst4 = 1'b0;
        bs0 = 1'b0; bs1 = 1'b0;
        tick4("walk00", 4'h1);
        bs0 = 1'b0; bs1 = 1'b1;
        tick4("walk01", 4'h2);
        bs0 = 1'b1; bs1 = 1'b0;
        tick4("walk10", 4'h4);
        bs0 = 1'b1; bs1 = 1'b1;
        tick4("walk11", 4'h8);
        rst4 = 1'b1;
        tick4("midrst", 4'h0);
        rst4 = 1'b0;
        tick4("postrst", 4'h8);

        // combinational instance, no clocking relied on
        cs0 = 1'b0; cs1 = 1'b0;
        comb("comb00", 4'h1);
        cs0 = 1'b0; cs1 = 1'b1;
        comb("comb01", 4'h2);
        cs0 = 1'b1; cs1 = 1'b0;
        comb("comb10", 4'h4);
        cs0 = 1'b1; cs1 = 1'b1;
        comb("comb11", 4'h8);
        rstc = 1'b1;
        comb("comb_rst11", 4'h8);
        cs0 = 1'b0; cs1 = 1'b1;
        comb("comb_rst01", 4'h2);
        rstc = 1'b0;

        total++;
        assert (q.size() == 0) else begin
            bad++;
            $error("FAIL queue_empty observed=%0d expected=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
